// File: rtl/regfile.sv
// Fifteen-entry register file (R0-R14) with two combinational read ports; address 15 reads the r15 input.
// Define REGFILE_BYPASS_EN to forward wd3 to a read port addressing the register being written this cycle.
module regfile #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we3,
  input  logic [3:0]       ra1,
  input  logic [3:0]       ra2,
  input  logic [3:0]       wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic [WIDTH-1:0] r15,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2
);

  logic [WIDTH-1:0] regs [0:14];
  logic             write_ok;

  assign write_ok = we3 && (wa3 != 4'd15);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < 15; i++) begin
        if (write_ok && (wa3 == 4'(i))) regs[i] <= wd3;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding is suppressed during reset so reads still return the cleared state.
  logic bypass_ok;
  assign bypass_ok = write_ok && !reset;
`endif

  always_comb begin
    rd1 = r15;
    for (int i = 0; i < 15; i++) begin
      if (ra1 == 4'(i)) rd1 = regs[i];
    end
`ifdef REGFILE_BYPASS_EN
    if (bypass_ok && (ra1 == wa3)) rd1 = wd3;
`endif
  end

  always_comb begin
    rd2 = r15;
    for (int i = 0; i < 15; i++) begin
      if (ra2 == 4'(i)) rd2 = regs[i];
    end
`ifdef REGFILE_BYPASS_EN
    if (bypass_ok && (ra2 == wa3)) rd2 = wd3;
`endif
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: shadow register model feeds an expectation queue compared against rd1/rd2.
// Honours REGFILE_BYPASS_EN the same way the design does.
module tb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        we3;
  logic [3:0]  ra1, ra2, wa3;
  logic [31:0] wd3, r15;
  logic [31:0] rd1, rd2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] model [0:14];

  regfile #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .we3(we3),
    .ra1(ra1), .ra2(ra2), .wa3(wa3),
    .wd3(wd3), .r15(r15),
    .rd1(rd1), .rd2(rd2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Expected read value as seen by a port right now, including a pending same-cycle write.
  function automatic logic [31:0] expRead(input logic [3:0] a);
    if (a == 4'd15) return r15;
`ifdef REGFILE_BYPASS_EN
    if (we3 && !reset && (wa3 == a)) return wd3;
`endif
    return model[a];
  endfunction

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctl);
    case (ctl)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      default: return 32'h0;
    endcase
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 15; i++) model[i] = 32'h0;
  endtask

  task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [31:0] wd);
    @(negedge clk);
    we3 = we;
    wa3 = wa;
    wd3 = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    if (we3 && !reset && (wa3 != 4'd15)) model[wa3] = wd3;
    @(negedge clk);
    we3 = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [3:0] a1, input logic [3:0] a2);
    exp_t e;
    ra1 = a1;
    ra2 = a2;
    e.tag = {tag, ".rd1"}; e.value = expRead(a1); expQ.push_back(e);
    e.tag = {tag, ".rd2"}; e.value = expRead(a2); expQ.push_back(e);
    #1;
    e = expQ.pop_front();
    checkOutput(e.tag, rd1, e.value);
    e = expQ.pop_front();
    checkOutput(e.tag, rd2, e.value);
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 16; i++) readCheck($sformatf("%s_r%0d", tag, i), 4'(i), 4'(15 - i));
  endtask

  initial begin
    reset = 1'b1;
    we3 = 1'b0; wa3 = 4'd0; wd3 = 32'h0;
    ra1 = 4'd0; ra2 = 4'd0;
    r15 = 32'h0000_0108;
    clearModel();

    #2;
    sweep("reset");

    // Write attempted while reset is held must be lost and must not forward.
    applyStimulus(1'b1, 4'd4, 32'hCAFE_F00D);
    readCheck("rst_wr_pending", 4'd4, 4'd4);
    checkOutput("rst_wr_pending_const", rd1, 32'h0);
    tick();
    readCheck("rst_wr_lost", 4'd4, 4'd15);

    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 4'd4, 32'h0BAD_CAFE);
    tick();
    readCheck("first_write", 4'd4, 4'd4);
    checkOutput("first_write_const", rd1, 32'h0BAD_CAFE);

    // Asynchronous clear in the middle of the low phase.
    applyStimulus(1'b1, 4'd3, 32'h1234_5678);
    tick();
    readCheck("r3_written", 4'd3, 4'd0);
    #1 reset = 1'b1;
    clearModel();
    readCheck("async_clear", 4'd3, 4'd4);
    checkOutput("async_clear_const", rd1, 32'h0);
    reset = 1'b0;

    applyStimulus(1'b1, 4'd5, 32'hDEAD_BEEF);
    tick();
    readCheck("r5_both", 4'd5, 4'd5);
    checkOutput("r5_rd2_const", rd2, 32'hDEAD_BEEF);
    sweep("after_r5");

    r15 = 32'h0000_0108;
    applyStimulus(1'b1, 4'd15, 32'hFFFF_FFFF);
    readCheck("r15_pending", 4'd15, 4'd15);
    tick();
    readCheck("r15_read", 4'd0, 4'd15);
    checkOutput("r15_const", rd2, 32'h0000_0108);
    sweep("after_r15");

    applyStimulus(1'b0, 4'd2, 32'hAAAA_5555);
    tick();
    readCheck("we_off", 4'd2, 4'd2);
    checkOutput("we_off_const", rd1, 32'h0);

    // Same-cycle read of the register being written.
    applyStimulus(1'b1, 4'd7, 32'h1);
    tick();
    applyStimulus(1'b1, 4'd7, 32'h2);
    readCheck("same_cycle", 4'd7, 4'd6);
`ifdef REGFILE_BYPASS_EN
    checkOutput("same_cycle_const", rd1, 32'h2);
`else
    checkOutput("same_cycle_const", rd1, 32'h1);
`endif
    tick();
    readCheck("same_cycle_after", 4'd7, 4'd7);
    checkOutput("same_cycle_after_const", rd1, 32'h2);

    applyStimulus(1'b1, 4'd1, 32'h1);
    tick();
    applyStimulus(1'b1, 4'd2, 32'h2);
    tick();
    readCheck("alu_ops", 4'd1, 4'd2);
    checkOutput("alu_and", alu(rd1, rd2, 3'b010), 32'h0);
    checkOutput("alu_or",  alu(rd1, rd2, 3'b011), 32'h3);
    checkOutput("alu_add", alu(rd1, rd2, 3'b000), 32'h3);

    for (int n = 0; n < 120; n++) begin
      logic [3:0] wa;
      logic [3:0] a2;
      wa = 4'($urandom_range(0, 15));
      a2 = 4'($urandom_range(0, 15));
      applyStimulus(1'($urandom_range(0, 1)), wa, $urandom);
      r15 = $urandom;
      readCheck($sformatf("rnd%0d_pre", n), wa, a2);
      tick();
      readCheck($sformatf("rnd%0d_post", n), wa, a2);
      if (n % 40 == 39) begin
        #1 reset = 1'b1;
        clearModel();
        readCheck($sformatf("rnd%0d_rst", n), wa, a2);
        reset = 1'b0;
      end
    end
    sweep("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter WIDTH, default 32, data width of every register and data port.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 we3  input  1  write enable for write port 3.
REQ-005 ra1  input  4  read address, port 1 (ALU operand A source).
REQ-006 ra2  input  4  read address, port 2 (ALU operand B source).
REQ-007 wa3  input  4  write address, port 3.
REQ-008 wd3  input  WIDTH  write data, port 3 (ALU result writeback).
REQ-009 r15  input  WIDTH  program-counter value (PC+8) supplied by fetch logic.
REQ-010 rd1  output  WIDTH  read data, port 1; drives ALU input a.
REQ-011 rd2  output  WIDTH  read data, port 2; drives ALU input b.

Function
REQ-012 Storage SHALL be 15 registers, R0-R14, each WIDTH bits; R15 SHALL have no storage.
REQ-013 Reads SHALL be combinational, zero latency: rdN = R[raN] for raN in 0-14.
REQ-014 raN = 15 SHALL return r15 input directly, on either port, independent of we3/wa3.
REQ-015 On rising clk with we3=1 and wa3 in 0-14, R[wa3] SHALL take wd3; all other registers SHALL hold.
REQ-016 we3=1 with wa3=15 SHALL be ignored; no register changes.
REQ-017 we3=0 SHALL leave all registers unchanged regardless of wa3/wd3.
REQ-018 Both read ports SHALL operate independently; ra1=ra2 SHALL return identical values on rd1 and rd2.
REQ-019 Write-then-read: value written at edge N SHALL be visible on rd1/rd2 from edge N onward (after clk-to-q).
REQ-020 Same-cycle read of the address being written: behaviour set by REQ-026/027.
REQ-021 No X SHALL propagate to rd1/rd2 after reset for any legal address.

Reset
REQ-022 reset=1 SHALL, asynchronously and without waiting for clk, clear R0-R14 to 0.
REQ-023 While reset=1, writes SHALL be blocked; rd1/rd2 SHALL read 0 for addresses 0-14 and r15 for address 15.
REQ-024 Reset asserted in the same cycle as a write SHALL win; the write SHALL be lost.
REQ-025 After reset deassertion, the first rising clk with we3=1 SHALL perform a normal write.

Configuration
REQ-026 With macro REGFILE_BYPASS_EN defined: when we3=1, wa3 in 0-14, reset=0 and raN=wa3, rdN SHALL return wd3 combinationally in that same cycle (write-through forwarding).
REQ-027 Without REGFILE_BYPASS_EN: rdN SHALL return the stored (pre-write) R[raN] until the write edge, then the new value.
REQ-028 Bypass SHALL never apply to address 15 or while reset=1.

Verification
REQ-029 Reset: pulse reset mid-cycle (no clk edge) after writing R3=0x12345678 -> rd1 with ra1=3 reads 0x00000000 immediately.
REQ-030 Write/read: we3=1, wa3=5, wd3=0xDEADBEEF, edge; ra1=5, ra2=5 -> rd1=rd2=0xDEADBEEF; R0-R4, R6-R14 still 0.
REQ-031 R15: r15=0x00000108, we3=1, wa3=15, wd3=0xFFFFFFFF, edge; ra2=15 -> rd2=0x00000108; all R0-R14 unchanged.
REQ-032 Write disable: we3=0, wa3=2, wd3=0xAAAA5555, edge -> rd1 (ra1=2) retains prior value 0x00000000.
REQ-033 Same-cycle read: R7=0x1, then we3=1, wa3=7, wd3=0x2, ra1=7 before edge -> rd1=0x2 with REGFILE_BYPASS_EN, 0x1 without; 0x2 after edge in both builds.
REQ-034 ALU pairing: write R1=0x1, R2=0x2; ra1=1, ra2=2 feed ALU control 3'b010 (AND) -> ALU result 0x0; control 3'b011 (OR) -> 0x3; control 3'b000 (ADD) -> 0x3.
